rr_arb4_sel: RTL and testbench
==============================

# rr_arb4_sel

Four-requester round-robin arbiter that generates the 2-bit select for the downstream 4:1 mux (`sel_o` drives the mux `sel_i`). Each source raises a request and the arbiter grants one owner at a time, holding the select stable until the transfer completes. Grants are registered, one-hot and fair, with back-to-back hand-over and no idle bubble. An optional watchdog revokes a grant that is held too long.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles one grant may be held (≥1). Used only when `RR_ARB4_TIMEOUT_EN` is defined.

- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_i`  in  4  request per source; bit n maps to mux input n (0=a, 1=b, 2=c, 3=d).
- `done_i`  in  1  current owner's transfer is complete; release the grant.
- `gnt_o`  out  4  one-hot grant, all-zero when idle.
- `sel_o`  out  2  binary index of the owner, feeding the mux select.
- `busy_o`  out  1  a grant is active (`gnt_o != 0`).
- `timeout_o`  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- State machine has two states:
  - IDLE (reset state).
  - GRANT.
- Pointer `ptr[1:0]` holds the last granted index. Reset value is 3, so index 0 has first priority.
- Arbitration searches `req_i` from `ptr+1` upward, wrapping 3→0. The first set bit wins. `ptr` ends the search as lowest priority.
- IDLE:
  - Any `req_i` bit set → winner is granted at the next edge and the state moves to GRANT.
  - `done_i` is ignored.
- GRANT: the owner keeps the grant while `req_i[owner]`=1 and `done_i`=0.
- Release occurs on `done_i`=1 or `req_i[owner]`=0. Both at once count as a single release.
- On release:
  - `ptr` is set to the owner, then arbitration runs over the current `req_i`.
  - Winner exists → grant it at the same edge and stay in GRANT (back-to-back). The owner may be re-granted only if it is the sole requester.
  - No winner → go to IDLE with `gnt_o`=0 and `busy_o`=0.
- `sel_o` holds its last value in IDLE so the mux output stays steady. It changes only when a new grant is issued.
- Reset values:
  - `gnt_o`=4'b0000, `sel_o`=2'd0, `busy_o`=0, `timeout_o`=0.
  - `ptr`=3, state IDLE, timeout counter 0.
- Reset asserted mid-grant drops the grant immediately (asynchronously). No release bookkeeping is performed.

## Timing
- All outputs are registered.
- A request sampled at edge k while in IDLE appears on `gnt_o`/`sel_o`/`busy_o` after edge k (1-cycle latency).
- A release sampled at edge k moves the grant to the next owner after the same edge k. There is no dead cycle between owners.
- `gnt_o`, `sel_o` and `busy_o` always change on the same edge and are mutually consistent.
- Requests arriving while another source owns the grant are not lost. They are served in rotation order at the next release.

## Configuration
- `RR_ARB4_TIMEOUT_EN` defined:
  - A counter clears to 0 on every new grant and increments each cycle the same grant is held.
  - If the counter equals `TIMEOUT_CYCLES-1` at an edge with no release, the grant is forcibly revoked at that edge. The owner therefore holds for at most `TIMEOUT_CYCLES` cycles.
  - On a forced revoke, `ptr` is set to the owner and the owner is masked out of that single arbitration. The next requester wins; if there is none, the state goes to IDLE.
  - `timeout_o` is 1 for exactly the cycle following the revoke edge.
- `RR_ARB4_TIMEOUT_EN` not defined:
  - No counter exists.
  - `timeout_o` is tied to 0.
  - A grant is held indefinitely until release.

## Test plan
- Reset, then `req_i`=4'b0001 → `gnt_o`=0001, `sel_o`=0, `busy_o`=1 one cycle later. Pulse `done_i` with `req_i`=0 → `gnt_o`=0, `busy_o`=0, `sel_o` stays 0.
- Hold `req_i`=4'b1111 and pulse `done_i` every cycle → `sel_o` sequence 0,1,2,3,0 with no gaps and `busy_o` constantly 1.
- Source 2 owns the grant, then `req_i` goes 0100→1001 in the same cycle (owner drops) → next grant is 3 (search starts at 3), not 0.
- Owner 1 with `done_i`=1 while `req_i`=4'b0010 (sole requester) → source 1 is re-granted back-to-back, `busy_o` stays 1.
- `rst_ni` driven low mid-grant with `gnt_o`=0100 → `gnt_o`=0, `sel_o`=0, `busy_o`=0 immediately. After reset release with `req_i`=1111 → first grant goes to 0.
- With `RR_ARB4_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, source 0 holds `req_i`=0011 without `done_i`:
  - Grant 0 lasts exactly 4 cycles, then grant passes to 1 with `timeout_o`=1 for 1 cycle.
  - With `req_i`=0001 only, timeout → IDLE, then source 0 is re-granted one cycle later.

Source files
------------

// File: rtl/rr_arb4_sel.sv
// -----------------------------------------------------------------------------
// rr_arb4_sel
//
// Four-requester round-robin arbiter producing the 2-bit select for a
// downstream 4:1 mux. One owner at a time; the grant is held until the owner
// signals done_i or drops its request. On release the next requester in
// rotation order takes over at the same edge, so there is no idle cycle
// between owners.
//
// Optional watchdog: define RR_ARB4_TIMEOUT_EN to revoke a grant that has been
// held for TIMEOUT_CYCLES cycles. Without the macro, timeout_o is tied to 0
// and a grant lasts until release.
//
// Parameters
//   TIMEOUT_CYCLES  maximum cycles a grant may be held (>= 1), watchdog only
//
// Ports
//   clk_i      in   1  clock, rising edge
//   rst_ni     in   1  asynchronous active-low reset
//   req_i      in   4  per-source request, bit n = mux input n
//   done_i     in   1  current owner's transfer is complete
//   gnt_o      out  4  one-hot grant, zero when idle
//   sel_o      out  2  binary index of owner (holds its value while idle)
//   busy_o     out  1  a grant is active
//   timeout_o  out  1  one-cycle pulse after a forced revoke
// -----------------------------------------------------------------------------
module rr_arb4_sel #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] req_i,
    input  logic       done_i,
    output logic [3:0] gnt_o,
    output logic [1:0] sel_o,
    output logic       busy_o,
    output logic       timeout_o
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;
    logic       busy_q,  busy_d;
    logic [1:0] ptr_q,   ptr_d;

    logic [2:0] pick;       // {found, index}
    logic       rel;        // owner released the grant this cycle
    logic       expire;     // watchdog forces a revoke this cycle
    logic [3:0] arb_req;    // requests taking part in this arbitration

    // Round-robin search starting just above 'last' and wrapping, so that
    // 'last' itself is considered only after the other three sources.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk from lowest to highest priority; the last hit wins.
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

`ifdef RR_ARB4_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        pick    = 3'b000;
        rel     = 1'b0;
        expire  = 1'b0;
        arb_req = req_i;
`ifdef RR_ARB4_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                // done_i has no meaning without an owner.
                pick = rr_pick(req_i, ptr_q);
                if (pick[2]) begin
                    state_d = S_GRANT;
                    gnt_d   = 4'b0001 << pick[1:0];
                    sel_d   = pick[1:0];
                    busy_d  = 1'b1;
`ifdef RR_ARB4_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end

            S_GRANT: begin
                rel = done_i | ~req_i[sel_q];
`ifdef RR_ARB4_TIMEOUT_EN
                expire = ~rel && (cnt_q == CNT_LIMIT);
`endif
                if (rel || expire) begin
                    ptr_d = sel_q;
                    // A revoked owner may not win its own hand-over.
                    if (expire) begin
                        arb_req = req_i & ~(4'b0001 << sel_q);
                    end
                    pick = rr_pick(arb_req, sel_q);
                    if (pick[2]) begin
                        gnt_d  = 4'b0001 << pick[1:0];
                        sel_d  = pick[1:0];
                        busy_d = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                    end
`ifdef RR_ARB4_TIMEOUT_EN
                    cnt_d     = '0;
                    timeout_d = expire;
`endif
                end else begin
`ifdef RR_ARB4_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            ptr_q   <= 2'd3;   // makes source 0 the first winner after reset
`ifdef RR_ARB4_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
`ifdef RR_ARB4_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt_o  = gnt_q;
    assign sel_o  = sel_q;
    assign busy_o = busy_q;
`ifdef RR_ARB4_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb4_sel.sv
// -----------------------------------------------------------------------------
// tb_rr_arb4_sel
//
// Directed bench for rr_arb4_sel. Inputs change 1 ns after a rising edge and
// outputs are checked at that same point, away from the active edge. The
// watchdog scenarios are built in when RR_ARB4_TIMEOUT_EN is defined
// (TIMEOUT_CYCLES = 4); otherwise the bench checks that a grant is held
// indefinitely with timeout_o low.
// -----------------------------------------------------------------------------
module tb_rr_arb4_sel;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       tmo;

    int n_checks = 0;
    int n_fail   = 0;

    rr_arb4_sel #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .done_i    (done),
        .gnt_o     (gnt),
        .sel_o     (sel),
        .busy_o    (busy),
        .timeout_o (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g,
                              input logic [1:0] s, input logic b,
                              input logic t);
        n_checks++;
        assert (gnt === g) else begin
            n_fail++;
            $error("FAIL %s.gnt observed=%b expected=%b", tag, gnt, g);
        end
        n_checks++;
        assert (sel === s) else begin
            n_fail++;
            $error("FAIL %s.sel observed=%0d expected=%0d", tag, sel, s);
        end
        n_checks++;
        assert (busy === b) else begin
            n_fail++;
            $error("FAIL %s.busy observed=%b expected=%b", tag, busy, b);
        end
        n_checks++;
        assert (tmo === t) else begin
            n_fail++;
            $error("FAIL %s.timeout observed=%b expected=%b", tag, tmo, t);
        end
        $display("step %-14s gnt=%b sel=%0d busy=%b timeout=%b", tag, gnt, sel, busy, tmo);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        tick();
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // ---------------- single request, then release to idle ----------------
        req = 4'b0001;
        tick();
        expect_out("single_gnt", 4'b0001, 2'd0, 1'b1, 1'b0);
        req  = 4'b0000;
        done = 1'b1;
        tick();
        expect_out("single_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = 1'b0;
        tick();
        expect_out("idle_hold", 4'b0000, 2'd0, 1'b0, 1'b0);

        // ---------------- full rotation with done every cycle ----------------
        do_reset();
        req = 4'b1111;
        tick();
        expect_out("rot0", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        expect_out("rot1", 4'b0010, 2'd1, 1'b1, 1'b0);
        tick();
        expect_out("rot2", 4'b0100, 2'd2, 1'b1, 1'b0);
        tick();
        expect_out("rot3", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        expect_out("rot4", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b0;

        // ---------------- owner 2 drops, 0 and 3 arrive: 3 wins ----------------
        do_reset();
        req = 4'b0100;
        tick();
        expect_out("own2", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b1001;
        tick();
        expect_out("drop2_to3", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        expect_out("hold3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        expect_out("idle_sel3", 4'b0000, 2'd3, 1'b0, 1'b0);
        tick();
        expect_out("idle_sel3b", 4'b0000, 2'd3, 1'b0, 1'b0);

        // ---------------- sole requester re-granted back-to-back ----------------
        do_reset();
        req = 4'b0010;
        tick();
        expect_out("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        expect_out("regrant1", 4'b0010, 2'd1, 1'b1, 1'b0);
        // Owner 1 releases with 0 also requesting: search 2,3,0 picks 0.
        req = 4'b0011;
        tick();
        expect_out("own1_to0", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b0;

        // ---------------- pending request is served at next release ----------------
        do_reset();
        req = 4'b0001;
        tick();
        expect_out("pend_own0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0101;
        tick();
        expect_out("pend_hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        expect_out("pend_to2", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 1'b0;

        // ---------------- asynchronous reset mid-grant ----------------
        do_reset();
        req = 4'b0100;
        tick();
        expect_out("pre_arst", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("arst_now", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1111;
        #1;
        rst_n = 1'b1;
        tick();
        expect_out("post_arst", 4'b0001, 2'd0, 1'b1, 1'b0);

`ifdef RR_ARB4_TIMEOUT_EN
        // ---------------- watchdog: hand-over to next requester ----------------
        do_reset();
        req = 4'b0011;
        tick();
        expect_out("wd_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("wd_c2", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("wd_c3", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("wd_c4", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("wd_revoke", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick();
        expect_out("wd_pulse_end", 4'b0010, 2'd1, 1'b1, 1'b0);

        // ---------------- watchdog: sole requester goes idle, then re-granted ----------------
        do_reset();
        req = 4'b0001;
        tick();
        expect_out("wd1_c1", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        expect_out("wd1_c4", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("wd1_idle", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        expect_out("wd1_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
`else
        // ---------------- no watchdog: grant held indefinitely ----------------
        do_reset();
        req = 4'b0011;
        tick();
        expect_out("hold_start", 4'b0001, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        expect_out("hold_20", 4'b0001, 2'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        expect_out("hold_release", 4'b0010, 2'd1, 1'b1, 1'b0);
        done = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
